// File: rtl/klein_pkg.sv
// Shared KLEIN definitions: S-box, GF(2^8) helper, forward/inverse key schedule, FSM states.
package klein_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;

  function automatic int nr_for_keyw(input int kw);
    case (kw)
      64:      return 12;
      80:      return 16;
      96:      return 20;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'h7;  4'h1: return 4'h4;  4'h2: return 4'hA;  4'h3: return 4'h9;
      4'h4: return 4'h1;  4'h5: return 4'hF;  4'h6: return 4'hB;  4'h7: return 4'h0;
      4'h8: return 4'hC;  4'h9: return 4'h3;  4'hA: return 4'h2;  4'hB: return 4'h6;
      4'hC: return 4'h8;  4'hD: return 4'hE;  4'hE: return 4'hD;  default: return 4'h5;
    endcase
  endfunction

  function automatic logic [7:0] sb8(input logic [7:0] x);
    return {sbox(x[7:4]), sbox(x[3:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Key halves are right-aligned in 48 bits; h is the live half width (32/40/48).
  function automatic logic [47:0] hmask(input int unsigned h);
    return (48'd1 << h) - 48'd1;
  endfunction

  function automatic logic [47:0] rotl8(input logic [47:0] x, input int unsigned h);
    return ((x << 8) | (x >> (h - 8))) & hmask(h);
  endfunction

  function automatic logic [47:0] rotr8(input logic [47:0] x, input int unsigned h);
    return ((x >> 8) | (x << (h - 8))) & hmask(h);
  endfunction

  function automatic logic [47:0] sub_byte(input logic [47:0] x, input int unsigned p);
    logic [7:0] v;
    v = 8'(x >> p);
    return (x & ~(48'hFF << p)) | (48'(sb8(v)) << p);
  endfunction

  function automatic logic [95:0] ks_fwd(input logic [95:0] sk, input int unsigned kw,
                                         input logic [7:0] i);
    int unsigned h;
    logic [47:0] ar, br, na, nb;
    h  = kw / 2;
    ar = rotl8(48'(sk >> h) & hmask(h), h);
    br = rotl8(sk[47:0] & hmask(h), h);
    na = br ^ (48'(i) << (h - 24));
    nb = sub_byte(sub_byte(ar ^ br, h - 16), h - 24);
    return (96'(na) << h) | 96'(nb);
  endfunction

  // S-box is an involution, so re-applying it undoes the b' substitution.
  function automatic logic [95:0] ks_inv(input logic [95:0] sk, input int unsigned kw,
                                         input logic [7:0] i);
    int unsigned h;
    logic [47:0] na, nb, ar, br;
    h  = kw / 2;
    na = 48'(sk >> h) & hmask(h);
    nb = sub_byte(sub_byte(sk[47:0] & hmask(h), h - 16), h - 24);
    br = na ^ (48'(i) << (h - 24));
    ar = nb ^ br;
    return (96'(rotr8(ar, h)) << h) | 96'(rotr8(br, h));
  endfunction

endpackage

// File: rtl/klein_dec_round.sv
// One KLEIN inverse round: InvMixNibbles, inverse 2-byte rotation, S-box, round-key XOR.
module klein_dec_round
  import klein_pkg::*;
(
  input  logic [63:0] st,
  input  logic [63:0] rk,
  output logic [63:0] nxt
);

  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] b [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    for (int j = 0; j < 4; j++) begin
      b[j]  = c[8*(3-j) +: 8];
      x2    = xtime(b[j]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[j] = x8 ^ b[j];
      mb[j] = x8 ^ x2 ^ b[j];
      md[j] = x8 ^ x4 ^ b[j];
      me[j] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [63:0] mixed, rot, subd;

  always_comb begin
    subd  = '0;
    mixed = {inv_mix(st[63:32]), inv_mix(st[31:0])};
    rot   = {mixed[15:0], mixed[63:16]};
    for (int n = 0; n < 16; n++) subd[4*n +: 4] = sbox(rot[4*n +: 4]);
    nxt   = subd ^ rk;
  end

endmodule

// File: rtl/klein_dec_iter.sv
// Iterative KLEIN-64/80/96 decryptor: one inverse round per clock, inverse key schedule on the fly.
module klein_dec_iter
  import klein_pkg::*;
#(
  parameter int KEY_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      cipher,
  input  logic [KEY_W-1:0] key,
  input  logic             key_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      text,
  output logic             busy
);

  localparam int NR = nr_for_keyw(KEY_W);
  localparam logic [4:0] NR5 = 5'(NR);

  if (KEY_W != 64 && KEY_W != 80 && KEY_W != 96) begin : g_bad_keyw
    $error("klein_dec_iter: KEY_W must be 64, 80 or 96");
  end

  state_t           state, nstate;
  logic [4:0]       rcnt;
  logic [63:0]      st, cipher_reg, rnd;
  logic [KEY_W-1:0] ks, ks_nx, ks_pv;

  assign ks_nx    = KEY_W'(ks_fwd(96'(ks), KEY_W, {3'b0, rcnt}));
  assign ks_pv    = KEY_W'(ks_inv(96'(ks), KEY_W, {3'b0, rcnt}));
  assign in_ready = rst_n & (state == IDLE);
  assign busy     = (state != IDLE);

  klein_dec_round u_round (
    .st  (st),
    .rk  (ks_pv[KEY_W-1 -: 64]),
    .nxt (rnd)
  );

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid && in_ready) nstate = key_mode ? DECRYPT : EXPAND;
      EXPAND:  if (rcnt == NR5) nstate = DECRYPT;
      DECRYPT: if (rcnt == 5'd1) nstate = DONE;
      DONE:    if (out_valid && out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rcnt       <= '0;
      st         <= '0;
      ks         <= '0;
      cipher_reg <= '0;
      out_valid  <= 1'b0;
      text       <= '0;
    end else begin
      state <= nstate;
      case (state)
        IDLE: if (in_valid) begin
          cipher_reg <= cipher;
          ks         <= key;
          // A final round key needs no expansion: whiten right away.
          if (key_mode) begin
            st   <= cipher ^ key[KEY_W-1 -: 64];
            rcnt <= NR5;
          end else begin
            rcnt <= 5'd1;
          end
        end
        EXPAND: begin
          ks <= ks_nx;
          if (rcnt == NR5) st <= cipher_reg ^ ks_nx[KEY_W-1 -: 64];
          else             rcnt <= rcnt + 5'd1;
        end
        DECRYPT: begin
          ks   <= ks_pv;
          st   <= rnd;
          rcnt <= rcnt - 5'd1;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            text      <= st;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_klein_dec_iter.sv
// Scoreboard bench: KLEIN-64/80/96 decryptors side by side against a byte-oriented encrypt model.
module tb_klein_dec_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, key_mode = 1'b0, out_ready = 1'b1;
  logic [63:0] cph [3];
  logic [63:0] k64 = '0;
  logic [79:0] k80 = '0;
  logic [95:0] k96 = '0;
  logic        ir [3], ov [3], bz [3];
  logic [63:0] txt [3];

  klein_dec_iter #(.KEY_W(64)) u64 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .cipher(cph[0]), .key(k64), .key_mode(key_mode), .out_valid(ov[0]), .out_ready(out_ready),
    .text(txt[0]), .busy(bz[0]));
  klein_dec_iter #(.KEY_W(80)) u80 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .cipher(cph[1]), .key(k80), .key_mode(key_mode), .out_valid(ov[1]), .out_ready(out_ready),
    .text(txt[1]), .busy(bz[1]));
  klein_dec_iter #(.KEY_W(96)) u96 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .cipher(cph[2]), .key(k96), .key_mode(key_mode), .out_valid(ov[2]), .out_ready(out_ready),
    .text(txt[2]), .busy(bz[2]));

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model (encrypt direction, byte arrays) ----
  function automatic logic [3:0] s4(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h74A91FB0C3268ED5;
    return t[60 - 4*int'(x) +: 4];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
  endfunction

  function automatic logic [31:0] mixc(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3, b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3, xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3)};
  endfunction

  function automatic int nrof(input int kw);
    return (kw == 64) ? 12 : (kw == 80) ? 16 : 20;
  endfunction

  function automatic logic [95:0] kstep(input logic [95:0] k, input int kw, input int i);
    logic [7:0] a [6], b [6], na [6], nb [6];
    logic [95:0] r;
    int hb;
    hb = kw / 16;
    a = '{default: 8'h00}; b = '{default: 8'h00};
    na = '{default: 8'h00}; nb = '{default: 8'h00};
    for (int j = 0; j < hb; j++) begin
      a[j] = k[8*(2*hb-1-j) +: 8];
      b[j] = k[8*(hb-1-j) +: 8];
    end
    for (int j = 0; j < hb; j++) begin
      na[j] = b[(j+1) % hb];
      nb[j] = a[(j+1) % hb] ^ b[(j+1) % hb];
    end
    na[2] = na[2] ^ 8'(i);
    nb[1] = {s4(nb[1][7:4]), s4(nb[1][3:0])};
    nb[2] = {s4(nb[2][7:4]), s4(nb[2][3:0])};
    r = '0;
    for (int j = 0; j < hb; j++) begin
      r[8*(2*hb-1-j) +: 8] = na[j];
      r[8*(hb-1-j) +: 8]   = nb[j];
    end
    return r;
  endfunction

  function automatic logic [95:0] ksched(input logic [95:0] k, input int kw);
    for (int r = 1; r <= nrof(kw); r++) k = kstep(k, kw, r);
    return k;
  endfunction

  function automatic logic [63:0] enc(input logic [63:0] p, input logic [95:0] k, input int kw);
    logic [63:0] s;
    s = p;
    for (int r = 1; r <= nrof(kw); r++) begin
      s = s ^ 64'(k >> (kw - 64));
      for (int j = 0; j < 16; j++) s[4*j +: 4] = s4(s[4*j +: 4]);
      s = {s[47:0], s[63:48]};
      s = {mixc(s[63:32]), mixc(s[31:0])};
      k = kstep(k, kw, r);
    end
    return s ^ 64'(k >> (kw - 64));
  endfunction

  // ---- scoreboard ----
  logic [63:0] exp_q [3][$];
  int          acc_q [3][$];
  int          lat_q [3][$];
  logic        pov [3];
  logic [63:0] ptxt [3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        pov[d] <= 1'b0;
      end else begin
        if (pov[d]) begin
          chk($sformatf("hold_v%0d", d), 64'(ov[d]), 64'd1);
          chk($sformatf("hold_t%0d", d), txt[d], ptxt[d]);
        end else if (ov[d]) begin
          if (acc_q[d].size() == 0) chk($sformatf("spurious%0d", d), 64'(ov[d]), 64'd0);
          else chk($sformatf("lat%0d", d), 64'(cyc - acc_q[d][0]), 64'(lat_q[d][0]));
        end
        if (ov[d] && out_ready && exp_q[d].size() != 0) begin
          chk($sformatf("text%0d", d), txt[d], exp_q[d].pop_front());
          void'(acc_q[d].pop_front());
          void'(lat_q[d].pop_front());
        end
        pov[d]  <= ov[d] && !out_ready;
        ptxt[d] <= txt[d];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] p, input logic [95:0] k, input logic m,
                      input logic ovr, input logic [63:0] c64);
    int t, kw;
    logic [95:0] kk, kd;
    t = 0;
    while (!(ir[0] && ir[1] && ir[2]) && t < 400) begin step(); t++; end
    chk("ready", {61'd0, ir[0], ir[1], ir[2]}, 64'd7);
    for (int d = 0; d < 3; d++) begin
      kw = 64 + 16*d;
      kk = k & ((96'd1 << kw) - 96'd1);
      kd = m ? ksched(kk, kw) : kk;
      cph[d] = (d == 0 && ovr) ? c64 : enc(p, kk, kw);
      case (d)
        0:       k64 = kd[63:0];
        1:       k80 = kd[79:0];
        default: k96 = kd;
      endcase
      exp_q[d].push_back(p);
      acc_q[d].push_back(cyc + 1);
      lat_q[d].push_back(m ? nrof(kw) + 1 : 2*nrof(kw) + 1);
    end
    key_mode = m;
    in_valid = 1'b1;
    step();
    // Garbage on every input while all cores are busy must be ignored.
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      key_mode = $urandom_range(0, 1);
      k64 = {$urandom, $urandom};
      k80 = {$urandom, $urandom, $urandom};
      k96 = {$urandom, $urandom, $urandom};
      for (int d = 0; d < 3; d++) cph[d] = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 400) begin
      step(); t++;
    end
    chk("drain", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) cph[d] = '0;
    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ir%0d", d), 64'(ir[d]), 64'd0);
      chk($sformatf("rst_ov%0d", d), 64'(ov[d]), 64'd0);
      chk($sformatf("rst_bz%0d", d), 64'(bz[d]), 64'd0);
      chk($sformatf("rst_tx%0d", d), txt[d], 64'd0);
    end
    rst_n = 1'b1;
    step();
    for (int d = 0; d < 3; d++) chk($sformatf("post_ir%0d", d), 64'(ir[d]), 64'd1);

    // Published KLEIN-64 vectors; the wider cores get model ciphertexts of the same block.
    send(64'hFFFFFFFFFFFFFFFF, 96'h0, 1'b0, 1'b1, 64'hCDC0B51F14722BBE);
    send(64'h0000000000000000, 96'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 64'h6456764E8602E154);
    send(64'hFFFFFFFFFFFFFFFF, 96'h1234567890ABCDEF, 1'b1, 1'b1, 64'h592356C4997176C8);
    drain();

    for (int m = 0; m < 2; m++)
      for (int it = 0; it < 40; it++)
        send({$urandom, $urandom}, {$urandom, $urandom, $urandom}, 1'(m), 1'b0, 64'h0);
    drain();

    // Backpressure: every core parks in DONE with out_ready low.
    out_ready = 1'b0;
    send({$urandom, $urandom}, {$urandom, $urandom, $urandom}, 1'b0, 1'b0, 64'h0);
    repeat (60) step();
    for (int d = 0; d < 3; d++) chk($sformatf("bp_ov%0d", d), 64'(ov[d]), 64'd1);
    out_ready = 1'b1;
    drain();

    // Reset while the 64-bit core is mid-DECRYPT.
    send({$urandom, $urandom}, {$urandom, $urandom, $urandom}, 1'b0, 1'b0, 64'h0);
    repeat (14) step();
    chk("pre_rst_bz0", 64'(bz[0]), 64'd1);
    rst_n = 1'b0;
    step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("mid_ov%0d", d), 64'(ov[d]), 64'd0);
      chk($sformatf("mid_bz%0d", d), 64'(bz[d]), 64'd0);
      chk($sformatf("mid_tx%0d", d), txt[d], 64'd0);
      exp_q[d].delete();
      acc_q[d].delete();
      lat_q[d].delete();
    end
    rst_n = 1'b1;
    step();
    send(64'hFFFFFFFFFFFFFFFF, 96'h0, 1'b0, 1'b1, 64'hCDC0B51F14722BBE);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
